eth_header_parser: RTL and testbench
====================================

Name: eth_header_parser

Overview:
- Header-stage consumer of the Ethernet packet detector's control FSM.
- Enabled by enable_header; takes the first 14 bytes of each frame from the shared data bus.
- Captures destination MAC, source MAC and type/length, classifies type/length, and drives type_length_valid back to the control FSM.
- The FSM uses type_length_valid to enter its payload state.

Parameters:
- MAX_LENGTH, 16'h05DC, largest legal 802.3 length value (1500).
- MIN_ETHERTYPE, 16'h0600, smallest legal Ethernet II EtherType (1536).
- LOCAL_MAC, 48'h000000000000, station address; used only when HDR_ADDR_FILTER_EN is defined.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_header  in  1  from control FSM; data is a header byte this cycle.
- data  in  8  frame byte bus shared with the control FSM, MSB-first per field.
- dst_mac  out  48  captured destination MAC.
- src_mac  out  48  captured source MAC.
- type_length  out  16  captured type/length field.
- is_length  out  1  type_length <= MAX_LENGTH (802.3 frame).
- type_length_valid  out  1  header complete and type/length legal; to control FSM.
- header_error  out  1  header complete but type/length is in the illegal gap (MAX_LENGTH, MIN_ETHERTYPE).
- header_abort  out  1  one-cycle pulse: enable_header dropped mid-header.

Behaviour:
- Reset (reset=0, async): state=IDLE, byte counter=0, every output 0.
- States: IDLE, DST (bytes 0-5), SRC (bytes 6-11), TL (bytes 12-13), HOLD.
- 4-bit byte counter, 0..13; counts only on cycles with enable_header=1; never wraps past 13.
- IDLE, enable_header=1:
  - Latch the byte into dst_mac[47:40], counter=1, go to DST.
  - Clear type_length_valid, header_error and is_length on the same edge.
- DST/SRC/TL capture: each enabled byte shifts into its field at position given by the counter; boundary transitions at counter 5->6 and 11->12.
- TL, second byte (counter=13), on the same edge:
  - Form type_length.
  - is_length <= (value <= MAX_LENGTH).
  - type_length_valid <= (value <= MAX_LENGTH) or (value >= MIN_ETHERTYPE).
  - header_error <= not type_length_valid.
  - Go to HOLD.
- Latency: type_length_valid and header_error are high the cycle after byte 13 is sampled.
- HOLD:
  - Outputs are held while enable_header=1; further bytes are ignored (the FSM normally drops enable_header here).
  - On enable_header=0, go to IDLE and clear type_length_valid and header_error on the next edge.
  - Net effect: valid overlaps exactly one cycle of enable_header=0.
  - Captured MAC fields and type_length persist until the next header starts.
- Abort: enable_header=0 while in DST, SRC or TL.
  - header_abort pulses 1 on the next cycle, state returns to IDLE, counter=0.
  - type_length_valid stays 0; partial fields are undefined and must not be used.
- enable_header low with no header in progress: no state change, no abort.
- Reset mid-header: immediate return to IDLE with all outputs 0.
- Back-to-back frames: a new enable_header=1 in IDLE on the cycle after HOLD exit is accepted as byte 0.

Optional Feature:
- Macro: HDR_ADDR_FILTER_EN.
- Defined:
  - dst_mac must equal LOCAL_MAC or 48'hFFFFFFFFFFFF; otherwise type_length_valid is forced to 0.
  - Extra output addr_mismatch (1 bit) is set with the same timing as header_error and cleared with it.
  - header_error is unaffected by address.
- Undefined: no address check; addr_mismatch port absent; LOCAL_MAC unused.

Decomposition:
- Package eth_pkg:
  - State encoding constants.
  - HDR_BYTES=14, DST_LAST=5, SRC_LAST=11.
  - Default MAX_LENGTH/MIN_ETHERTYPE values.
  - BROADCAST_MAC.
  - Shared with the control FSM and the future payload counter.
- One natural sub-module: eth_tl_classifier, combinational.
  - Input: a 16-bit value.
  - Outputs: is_length, legal.
  - Reused by the payload stage for packet_size checks.
- The capture/counter logic stays in the top.

Test Plan:
- Ethernet II: 14 bytes with dst=FF..FF, src=00:11:22:33:44:55, TL=16'h0800, enable_header held -> cycle after byte 13: type_length_valid=1, is_length=0, header_error=0, fields match.
- 802.3 length: TL=16'h002E -> type_length_valid=1, is_length=1; then enable_header=0 -> valid clears one cycle later.
- Illegal gap: TL=16'h05FF -> type_length_valid=0, header_error=1; TL=16'h05DC -> valid=1; TL=16'h0600 -> valid=1.
- Abort: enable_header drops after byte 8 -> header_abort=1 for exactly one cycle, state IDLE; a following full header parses correctly.
- Async reset: assert reset=0 mid-SRC between clock edges -> all outputs 0 immediately; after release, header from byte 0 parses.
- HDR_ADDR_FILTER_EN with LOCAL_MAC=02:00:00:00:00:01: dst=02:00:00:00:00:02, TL=0800 -> valid=0, addr_mismatch=1; broadcast dst -> valid=1.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared header-stage constants (state encoding, byte boundaries, field limits) and a byte-placement helper.
package eth_pkg;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DST  = 3'd1;
   localparam logic [2:0] S_SRC  = 3'd2;
   localparam logic [2:0] S_TL   = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   localparam int         HDR_BYTES = 14;
   localparam logic [3:0] DST_LAST  = 4'd5;
   localparam logic [3:0] SRC_LAST  = 4'd11;
   localparam logic [3:0] TL_LAST   = 4'(HDR_BYTES - 1);

   localparam logic [15:0] DEF_MAX_LENGTH    = 16'h05DC;
   localparam logic [15:0] DEF_MIN_ETHERTYPE = 16'h0600;
   localparam logic [47:0] BROADCAST_MAC     = 48'hFFFF_FFFF_FFFF;

   // Place byte b at MSB-first byte slot idx (0..5) of a 48-bit address field.
   function automatic logic [47:0] put_byte(input logic [47:0] field, input logic [2:0] idx,
                                            input logic [7:0] b);
      logic [47:0] f;
      f = field;
      for (int i = 0; i < 6; i++)
         if (idx == 3'(i)) f[47-8*i -: 8] = b;
      return f;
   endfunction

endpackage

// File: rtl/eth_tl_classifier.sv
// eth_tl_classifier: combinational 802.3 length / Ethernet II EtherType classification of a 16-bit type/length value.
module eth_tl_classifier
   import eth_pkg::*;
#(
   parameter logic [15:0] MAX_LENGTH    = DEF_MAX_LENGTH,
   parameter logic [15:0] MIN_ETHERTYPE = DEF_MIN_ETHERTYPE
) (
   input  logic [15:0] value_i,
   output logic        is_length_o,
   output logic        legal_o
);

   assign is_length_o = value_i <= MAX_LENGTH;
   assign legal_o     = is_length_o || (value_i >= MIN_ETHERTYPE);

endmodule

// File: rtl/eth_header_parser.sv
// eth_header_parser: captures the 14-byte Ethernet header, classifies type/length, optional destination address filter
module eth_header_parser
  import eth_pkg::*;
#(
  parameter logic [15:0] MAX_LENGTH    = DEF_MAX_LENGTH,
  parameter logic [15:0] MIN_ETHERTYPE = DEF_MIN_ETHERTYPE,
  parameter logic [47:0] LOCAL_MAC     = 48'h0000_0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_header,
  input  logic [7:0]  data,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] type_length,
  output logic        is_length,
  output logic        type_length_valid,
  output logic        header_error,
  output logic        header_abort
`ifdef HDR_ADDR_FILTER_EN
  ,output logic       addr_mismatch
`endif
);
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] tl_q, tl_d;
  logic        is_len_q, is_len_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        mism_q, mism_d;
  logic [15:0] tl_val;
  logic        cls_is_len, cls_legal, addr_ok;
  assign tl_val = {tl_q[15:8], data};
  eth_tl_classifier #(
    .MAX_LENGTH   (MAX_LENGTH),
    .MIN_ETHERTYPE(MIN_ETHERTYPE)
  ) u_cls (
    .value_i    (tl_val),
    .is_length_o(cls_is_len),
    .legal_o    (cls_legal)
  );
`ifdef HDR_ADDR_FILTER_EN
  assign addr_ok       = (dst_q == LOCAL_MAC) || (dst_q == BROADCAST_MAC);
  assign addr_mismatch = mism_q;
`else
  assign addr_ok = 1'b1;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    src_d    = src_q;
    tl_d     = tl_q;
    is_len_d = is_len_q;
    valid_d  = valid_q;
    err_d    = err_q;
    abort_d  = 1'b0;
    mism_d   = mism_q;
    case (state_q)
      S_IDLE: begin
        if (enable_header) begin
          dst_d    = put_byte(dst_q, 3'd0, data);
          cnt_d    = 4'd1;
          state_d  = S_DST;
          valid_d  = 1'b0;
          err_d    = 1'b0;
          is_len_d = 1'b0;
          mism_d   = 1'b0;
        end
      end
      S_DST, S_SRC, S_TL: begin
        if (!enable_header) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (state_q == S_DST) begin
            dst_d   = put_byte(dst_q, cnt_q[2:0], data);
            state_d = (cnt_q == DST_LAST) ? S_SRC : S_DST;
          end else if (state_q == S_SRC) begin
            src_d   = put_byte(src_q, 3'(cnt_q - 4'd6), data);
            state_d = (cnt_q == SRC_LAST) ? S_TL : S_SRC;
          end else if (cnt_q == TL_LAST) begin
            tl_d     = tl_val;
            is_len_d = cls_is_len;
            valid_d  = cls_legal && addr_ok;
            err_d    = !cls_legal;
            mism_d   = !addr_ok;
            cnt_d    = cnt_q;
            state_d  = S_HOLD;
          end else begin
            tl_d[15:8] = data;
          end
        end
      end
      S_HOLD: begin
        if (!enable_header) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          mism_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      dst_q    <= '0;
      src_q    <= '0;
      tl_q     <= '0;
      is_len_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      tl_q     <= tl_d;
      is_len_q <= is_len_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      mism_q   <= mism_d;
    end
  end
  assign dst_mac           = dst_q;
  assign src_mac           = src_q;
  assign type_length       = tl_q;
  assign is_length         = is_len_q;
  assign type_length_valid = valid_q;
  assign header_error      = err_q;
  assign header_abort      = abort_q;
endmodule

// File: tb/tb_eth_header_parser.sv
// tb_eth_header_parser: randomized self-checking bench for eth_header_parser against a rule-level reference model.
module tb_eth_header_parser;

   localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
`ifdef HDR_ADDR_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [7:0]  data = 8'h00;
   logic [47:0] dst_mac, src_mac;
   logic [15:0] tl;
   logic        is_len, valid, err, abort;
   int          checks = 0;
   int          errors = 0;
`ifdef HDR_ADDR_FILTER_EN
   logic        mism;
`endif

   always #5 clk = ~clk;

   eth_header_parser #(.LOCAL_MAC(LOCAL)) dut (
      .clock            (clk),
      .reset            (rst_n),
      .enable_header    (en),
      .data             (data),
      .dst_mac          (dst_mac),
      .src_mac          (src_mac),
      .type_length      (tl),
      .is_length        (is_len),
      .type_length_valid(valid),
      .header_error     (err),
      .header_abort     (abort)
`ifdef HDR_ADDR_FILTER_EN
      ,.addr_mismatch   (mism)
`endif
   );

   function automatic logic m_legal(input logic [15:0] t);
      return (t <= 16'd1500) || (t >= 16'd1536);
   endfunction

   function automatic logic m_valid(input logic [47:0] d, input logic [15:0] t);
      return m_legal(t) && (!FILT || d == LOCAL || d == BCAST);
   endfunction

   function automatic logic [2:0] m_flags(input logic [47:0] d, input logic [15:0] t);
      return {m_valid(d, t), t <= 16'd1500, !m_legal(t)};
   endfunction

   task automatic send(input logic [111:0] hdr, input int n);
      for (int i = 0; i < n; i++) begin
         en = 1'b1;
         data = hdr[111-8*i -: 8];
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_cycle;
      en = 1'b0;
      data = 8'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      checks++;
      if ({dst_mac, src_mac, tl, is_len, valid, err, abort} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got dst=%h src=%h tl=%h flags=%b exp all zero",
                  dst_mac, src_mac, tl, {is_len, valid, err, abort});
      end
   endtask

   task automatic test_ethernet2;
      logic [111:0] hdr;
      hdr = {BCAST, 48'h0011_2233_4455, 16'h0800};
      send(hdr, 14);
      checks++;
      if ({dst_mac, src_mac, tl} !== hdr) begin
         errors++;
         $display("FAIL eth2_fields got %h exp %h", {dst_mac, src_mac, tl}, hdr);
      end
      checks++;
      if ({valid, is_len, err, abort} !== 4'b1000) begin
         errors++;
         $display("FAIL eth2_flags got %b exp 1000", {valid, is_len, err, abort});
      end
      data = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({dst_mac, src_mac, tl, valid} !== {hdr, 1'b1}) begin
         errors++;
         $display("FAIL hold_ignores_bytes got %h/%b exp %h/1", {dst_mac, src_mac, tl}, valid, hdr);
      end
      idle_cycle();
      checks++;
      if ({valid, err, abort} !== 3'b000 || {dst_mac, src_mac, tl} !== hdr) begin
         errors++;
         $display("FAIL eth2_exit got flags=%b fields=%h exp 000 %h", {valid, err, abort},
                  {dst_mac, src_mac, tl}, hdr);
      end
   endtask

   task automatic test_length;
      send({BCAST, 48'hA0B1_C2D3_E4F5, 16'h002E}, 14);
      checks++;
      if ({valid, is_len, err} !== 3'b110) begin
         errors++;
         $display("FAIL len_flags got %b exp 110", {valid, is_len, err});
      end
      idle_cycle();
      checks++;
      if ({valid, is_len, err} !== 3'b010) begin
         errors++;
         $display("FAIL len_exit got %b exp 010", {valid, is_len, err});
      end
   endtask

   task automatic test_gap;
      logic [15:0] vals [3] = '{16'h05FF, 16'h05DC, 16'h0600};
      foreach (vals[k]) begin
         send({BCAST, 48'h1234_5678_9ABC, vals[k]}, 14);
         checks++;
         if ({valid, is_len, err} !== m_flags(BCAST, vals[k]) || tl !== vals[k]) begin
            errors++;
            $display("FAIL gap_%h got flags=%b tl=%h exp %b", vals[k], {valid, is_len, err}, tl,
                     m_flags(BCAST, vals[k]));
         end
         idle_cycle();
      end
   endtask

   task automatic test_back_to_back;
      logic [47:0] d, s;
      logic [15:0] t;
      for (int n = 0; n < 30; n++) begin
         d = ($urandom_range(0, 2) == 0) ? BCAST : {16'($urandom), 32'($urandom)};
         s = {16'($urandom), 32'($urandom)};
         case ($urandom_range(0, 2))
            0: t = 16'($urandom);
            1: t = 16'($urandom_range(1490, 1545));
            default: t = 16'($urandom_range(0, 1600));
         endcase
         send({d, s, t}, 14);
         checks++;
         if ({dst_mac, src_mac, tl} !== {d, s, t} || {valid, is_len, err} !== m_flags(d, t)) begin
            errors++;
            $display("FAIL b2b_%0d got %h flags=%b exp %h flags=%b", n, {dst_mac, src_mac, tl},
                     {valid, is_len, err}, {d, s, t}, m_flags(d, t));
         end
         idle_cycle();
         checks++;
         if ({valid, err} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_exit_%0d got %b exp 00", n, {valid, err});
         end
      end
   endtask

   task automatic test_abort;
      send({16'($urandom), 32'($urandom), 16'($urandom), 32'($urandom), 16'($urandom)}, 9);
      idle_cycle();
      checks++;
      if ({abort, valid} !== 2'b10) begin
         errors++;
         $display("FAIL abort_pulse got %b exp 10", {abort, valid});
      end
      idle_cycle();
      checks++;
      if ({abort, valid} !== 2'b00) begin
         errors++;
         $display("FAIL abort_one_cycle got %b exp 00", {abort, valid});
      end
      send({BCAST, 48'h0A0B_0C0D_0E0F, 16'h86DD}, 14);
      checks++;
      if ({dst_mac, src_mac, tl, valid, err} !== {BCAST, 48'h0A0B_0C0D_0E0F, 16'h86DD, 2'b10}) begin
         errors++;
         $display("FAIL after_abort got %h %b", {dst_mac, src_mac, tl}, {valid, err});
      end
      idle_cycle();
   endtask

   task automatic test_idle_low;
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle_cycle();
         seen |= abort | valid | err;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL idle_low got activity=%b exp 0", seen);
      end
   endtask

   task automatic test_async_reset;
      send({BCAST, 48'h5555_6666_7777, 16'h0800}, 14);
      idle_cycle();
      send({BCAST, 48'h1111_2222_3333, 16'h0801}, 8);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({dst_mac, src_mac, tl, is_len, valid, err, abort} !== '0) begin
         errors++;
         $display("FAIL async_reset got dst=%h src=%h tl=%h flags=%b exp zero", dst_mac, src_mac,
                  tl, {is_len, valid, err, abort});
      end
      en = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send({BCAST, 48'hDEAD_BEEF_0042, 16'h0040}, 14);
      checks++;
      if ({dst_mac, src_mac, tl, valid, is_len} !== {BCAST, 48'hDEAD_BEEF_0042, 16'h0040, 2'b11}) begin
         errors++;
         $display("FAIL post_reset got %h %b", {dst_mac, src_mac, tl}, {valid, is_len});
      end
      idle_cycle();
   endtask

`ifdef HDR_ADDR_FILTER_EN
   task automatic test_addr_filter;
      send({48'h0200_0000_0002, 48'h0011_2233_4455, 16'h0800}, 14);
      checks++;
      if ({valid, err, mism} !== 3'b001) begin
         errors++;
         $display("FAIL filter_other got %b exp 001", {valid, err, mism});
      end
      idle_cycle();
      checks++;
      if (mism !== 1'b0) begin
         errors++;
         $display("FAIL filter_clear got %b exp 0", mism);
      end
      send({BCAST, 48'h0011_2233_4455, 16'h0800}, 14);
      checks++;
      if ({valid, mism} !== 2'b10) begin
         errors++;
         $display("FAIL filter_bcast got %b exp 10", {valid, mism});
      end
      idle_cycle();
      send({LOCAL, 48'h0011_2233_4455, 16'h0800}, 14);
      checks++;
      if ({valid, mism} !== 2'b10) begin
         errors++;
         $display("FAIL filter_local got %b exp 10", {valid, mism});
      end
      idle_cycle();
   endtask
`endif

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_ethernet2();
      test_length();
      test_gap();
      test_back_to_back();
      test_abort();
      test_idle_low();
      test_async_reset();
`ifdef HDR_ADDR_FILTER_EN
      test_addr_filter();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
